dm_cache_responder: RTL and testbench

- Direct-mapped, write-back, write-allocate cache that answers the CPU-side memory port: read/write/wmask/address/wdata in, resp/rdata out.
- One instance serves the instruction port and one serves the data port.
- Misses are filled from physical memory over a 256-bit line interface with its own read/write/resp handshake.
- Sits between the pipelined core and the memory arbiter.

---
 rtl/dm_cache_responder.sv | 174 +++++++++++++++++
 tb/tb_dm_cache_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_responder.sv
// dm_cache_responder: direct-mapped, write-back, write-allocate cache between a CPU word port and a line-wide memory
// Optional feature macro: DM_CACHE_PERF_CNT_EN (hit/miss counters; ports tied to 0 when undefined).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   mem_read/mem_write    CPU request, held until mem_resp (both set means write)
//   mem_wmask             byte enables for writes
//   mem_address           CPU byte address (bits [1:0] ignored)
//   mem_wdata             CPU write data
//   mem_resp/mem_rdata    one-cycle completion pulse and read word
//   pmem_read/pmem_write  line fill / writeback request, held until pmem_resp
//   pmem_address          line address, bits [4:0] always 0
//   pmem_wdata            writeback line
//   pmem_resp/pmem_rdata  memory completion pulse and fill line
//   hit_count/miss_count  performance counters
module dm_cache_responder #(
    parameter int S_INDEX   = 3,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [3:0]           mem_wmask,
    input  logic [31:0]          mem_address,
    input  logic [31:0]          mem_wdata,
    output logic                 mem_resp,
    output logic [31:0]          mem_rdata,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic                 pmem_resp,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);
    localparam int SETS  = 2 ** S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] WB     = 2'd2;
    localparam logic [1:0] FILL   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [31:2]          addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wmask_q;
    logic                 wr_q;
    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;
    logic [TAG_W-1:0]     tag_q  [SETS];
    logic [LINE_BITS-1:0] data_q [SETS];

    logic [S_INDEX-1:0]   idx;
    logic [TAG_W-1:0]     rtag;
    logic [2:0]           word;
    logic                 hit;
    logic                 take;
    logic                 wr_hit;
    logic                 wb_done;
    logic                 fill_done;
    logic [LINE_BITS-1:0] line;
    logic [LINE_BITS-1:0] wline;
    logic [31:0]          rword;
    logic [31:0]          bmask;
    logic                 unused_addr;

    // byte offset inside the word never selects anything: whole words are returned
    assign unused_addr = ^mem_address[1:0];

    assign idx       = addr_q[4+S_INDEX:5];
    assign rtag      = addr_q[31:5+S_INDEX];
    assign word      = addr_q[4:2];
    assign line      = data_q[idx];
    assign rword     = line[{word, 5'b0} +: 32];
    assign hit       = valid_q[idx] && (tag_q[idx] == rtag);
    assign take      = (state_q == IDLE) && (mem_read || mem_write);
    assign wr_hit    = (state_q == LOOKUP) && hit && wr_q;
    assign wb_done   = (state_q == WB) && pmem_resp;
    assign fill_done = (state_q == FILL) && pmem_resp;
    assign bmask     = {{8{wmask_q[3]}}, {8{wmask_q[2]}}, {8{wmask_q[1]}}, {8{wmask_q[0]}}};

    always_comb begin
        wline = line;
        wline[{word, 5'b0} +: 32] = (wdata_q & bmask) | (rword & ~bmask);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (mem_read || mem_write) ? LOOKUP : IDLE;
            LOOKUP:  state_d = hit ? IDLE : ((valid_q[idx] && dirty_q[idx]) ? WB : FILL);
            WB:      state_d = pmem_resp ? FILL : WB;
            default: state_d = pmem_resp ? LOOKUP : FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            wr_q    <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                addr_q  <= mem_address[31:2];
                wdata_q <= mem_wdata;
                wmask_q <= mem_wmask;
                wr_q    <= mem_write;
            end
            if (wr_hit)
                dirty_q[idx] <= 1'b1;
            if (wb_done)
                dirty_q[idx] <= 1'b0;
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // line storage needs no reset: valid bits gate every use of it
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[idx] <= pmem_rdata;
            tag_q[idx]  <= rtag;
        end else if (wr_hit) begin
            data_q[idx] <= wline;
        end
    end

    assign mem_resp     = (state_q == LOOKUP) && hit;
    assign mem_rdata    = (mem_resp && !wr_q) ? rword : 32'h0;
    assign pmem_read    = (state_q == FILL);
    assign pmem_write   = (state_q == WB);
    assign pmem_address = (state_q == WB)   ? {tag_q[idx], idx, 5'b0} :
                          (state_q == FILL) ? {rtag, idx, 5'b0} : 32'h0;
    assign pmem_wdata   = (state_q == WB) ? line : '0;

`ifdef DM_CACHE_PERF_CNT_EN
    logic        refill_q;
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    // refill_q marks the re-lookup after a fill so it is not counted as a hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refill_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            if (fill_done)
                refill_q <= 1'b1;
            else if (state_q == LOOKUP)
                refill_q <= 1'b0;
            if ((state_q == LOOKUP) && hit && !refill_q)
                hit_q <= hit_q + 32'd1;
            if ((state_q == LOOKUP) && !hit)
                miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = 32'h0;
    assign miss_count = 32'h0;
`endif
endmodule

// File: tb/tb_dm_cache_responder.sv
// tb_dm_cache_responder: directed plus randomized checks of dm_cache_responder against a flat-memory model
module tb_dm_cache_responder;
    logic         clk = 1'b0;
    logic         reset;
    logic         mem_read, mem_write;
    logic [3:0]   mem_wmask;
    logic [31:0]  mem_address, mem_wdata;
    logic         mem_resp;
    logic [31:0]  mem_rdata;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic [31:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    dm_cache_responder dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [255:0] bmem [int unsigned];
    logic [31:0]  ref_w [int unsigned];
    bit           res_v [8];
    bit           res_d [8];
    int unsigned  res_tag [8];
    int           fill_lat = 3;
    logic [255:0] last_wb = '0;
    int unsigned  exp_hits = 0;
    int unsigned  exp_miss = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [255:0] get_line(input int unsigned la);
        logic [255:0] l;
        if (bmem.exists(la)) return bmem[la];
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = (la * 32'h9E3779B1) ^ (w * 32'h01010101) ^ 32'h5A5A0000;
        return l;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [255:0] l;
        if (ref_w.exists(a >> 2)) return ref_w[a >> 2];
        l = get_line(a >> 5);
        return l[int'(a[4:2])*32 +: 32];
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = ref_read((la << 5) | 32'(w * 4));
        return l;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            res_v[i] = 1'b0;
            res_d[i] = 1'b0;
        end
        ref_w.delete();
        exp_hits = 0;
        exp_miss = 0;
    endtask

    // physical memory: answers each request fill_lat negedges after it appears
    initial begin
        int pend = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                pend = 0;
            end else if (reset || !(pmem_read || pmem_write)) begin
                pend = 0;
            end else begin
                chk("pmem_excl", pmem_read && pmem_write, 0);
                chk("pmem_align", pmem_address[4:0], 0);
                pend++;
                if (pend >= fill_lat) begin
                    if (pmem_write) begin
                        chk("wb_data", pmem_wdata, ref_line(pmem_address >> 5));
                        bmem[pmem_address >> 5] = pmem_wdata;
                        last_wb = pmem_wdata;
                    end else begin
                        pmem_rdata = get_line(pmem_address >> 5);
                    end
                    pmem_resp = 1'b1;
                    pend = 0;
                end
            end
        end
    end

    task automatic do_access(input bit rd, input bit wr, input logic [3:0] mask,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input bit drop, output logic [31:0] rdat);
        int          idx;
        int unsigned tg, la, old_la;
        bit          exp_hit, exp_wb, saw_fill, saw_wb, order_ok, done;
        int          cyc;
        logic [31:0] old, nw, exp_rd, wb_a, fill_a;
        idx = int'(addr[7:5]);
        tg = addr >> 8;
        la = addr >> 5;
        exp_hit = res_v[idx] && (res_tag[idx] == tg);
        exp_wb = !exp_hit && res_v[idx] && res_d[idx];
        old_la = (res_tag[idx] << 3) | idx;
        old = ref_read(addr);
        for (int b = 0; b < 4; b++)
            nw[b*8 +: 8] = mask[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
        exp_rd = wr ? 32'h0 : old;
        saw_fill = 0; saw_wb = 0; order_ok = 1; done = 0; cyc = 0;
        wb_a = '0; fill_a = '0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_wmask = mask; mem_address = addr; mem_wdata = wd;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (drop) begin
                mem_read = 1'b0;
                mem_write = 1'b0;
            end
            if (pmem_write) begin
                if (!saw_wb) wb_a = pmem_address;
                saw_wb = 1;
                if (saw_fill) order_ok = 0;
            end
            if (pmem_read) begin
                if (!saw_fill) fill_a = pmem_address;
                saw_fill = 1;
            end
            if (mem_resp) done = 1;
        end
        rdat = mem_rdata;
        mem_read = 1'b0;
        mem_write = 1'b0;
        chk("resp_timeout", done, 1);
        chk("rdata", mem_rdata, exp_rd);
        chk("fill_seen", saw_fill, !exp_hit);
        chk("wb_seen", saw_wb, exp_wb);
        if (exp_hit) chk("hit_latency", cyc, 1);
        if (exp_wb) begin
            chk("wb_addr", wb_a, old_la << 5);
            chk("wb_order", order_ok, 1);
        end
        if (!exp_hit) chk("fill_addr", fill_a, la << 5);
        if (!exp_hit) begin
            exp_miss++;
            res_v[idx] = 1'b1;
            res_tag[idx] = tg;
            res_d[idx] = 1'b0;
        end else begin
            exp_hits++;
        end
        if (wr) begin
            ref_w[addr >> 2] = nw;
            res_d[idx] = 1'b1;
        end
        @(posedge clk); #1;
        chk("resp_pulse", mem_resp, 0);
`ifdef DM_CACHE_PERF_CNT_EN
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_miss);
`else
        chk("hit_count_tied", hit_count, 0);
        chk("miss_count_tied", miss_count, 0);
`endif
    endtask

    initial begin
        logic [31:0]  r;
        logic [255:0] l;
        bit           got;
        mem_read = 0; mem_write = 0; mem_wmask = 0; mem_address = 0; mem_wdata = 0;
        reset = 1'b1;
        l = get_line(8);
        l[31:0] = 32'h1111_1111;
        l[63:32] = 32'h2222_2222;
        bmem[8] = l;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        reset = 1'b0;

        fill_lat = 3;
        do_access(1, 0, 4'h0, 32'h0000_0100, 32'h0, 0, r);
        chk("tp_first_read", r, 32'h1111_1111);
        do_access(1, 0, 4'h0, 32'h0000_0104, 32'h0, 0, r);
        chk("tp_hit_read", r, 32'h2222_2222);
        do_access(0, 1, 4'b0011, 32'h0000_0104, 32'hAAAA_BBBB, 0, r);
        do_access(1, 0, 4'h0, 32'h0000_0104, 32'h0, 0, r);
        chk("tp_merge", r, 32'h2222_BBBB);
        do_access(1, 0, 4'h0, 32'h0000_0200, 32'h0, 0, r);
        chk("tp_wb_word1", last_wb[63:32], 32'h2222_BBBB);

        // reset in the middle of a slow fill
        fill_lat = 50;
        @(negedge clk);
        mem_read = 1'b1;
        mem_address = 32'h0000_0300;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            got = pmem_read;
        end
        chk("fill_started", got, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_pmem_read", pmem_read, 0);
        chk("abort_pmem_address", pmem_address, 0);
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();

        fill_lat = 2;
        do_access(1, 0, 4'h0, 32'h0000_0104, 32'h0, 0, r);
        chk("post_reset_read", r, 32'h2222_BBBB);
        do_access(1, 1, 4'hF, 32'h0000_0108, 32'hDEAD_BEEF, 0, r);
        do_access(1, 0, 4'h0, 32'h0000_0108, 32'h0, 0, r);
        chk("both_is_write", r, 32'hDEAD_BEEF);

        // instruction-port style: read held constantly on a resident line
        @(negedge clk);
        mem_read = 1'b1;
        mem_address = 32'h0000_0104;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("b2b_resp", mem_resp, (i % 2) == 0);
            if (mem_resp) chk("b2b_rdata", mem_rdata, 32'h2222_BBBB);
        end
        mem_read = 1'b0;
        exp_hits += 3;

        // CPU drops the request mid-miss (dirty victim in set 0)
        do_access(1, 0, 4'h0, 32'h0000_0500, 32'h0, 1, r);

        for (int n = 0; n < 250; n++) begin
            int   op;
            logic [31:0] a;
            fill_lat = $urandom_range(1, 4);
            a = 32'($urandom_range(0, 1023));
            op = $urandom_range(0, 2);
            do_access(op != 1, op != 0, 4'($urandom), a, $urandom, $urandom_range(0, 7) == 0, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
